// File: rtl/eth_pcs_rx_sync_ctrl.sv
// 10GBASE-R receive block-lock FSM with gearbox slip control and optional high-BER monitor.
// Define ETH_PCS_RX_HI_BER_EN to build the BER timer, ber_cnt and o_hi_ber logic.
module eth_pcs_rx_sync_ctrl #(
  parameter int SH_CNT_MAX       = 64,
  parameter int SH_INVLD_MAX     = 16,
  parameter int SLIP_HOLDOFF     = 4,
  parameter int BER_TIMER_CYCLES = 40283,
  parameter int BER_INVLD_MAX    = 16
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_hdr_valid,
  input  logic [1:0] i_sync_hdr,
  output logic       o_slip,
  output logic       o_rx_lock,
  output logic       o_hi_ber,
  output logic [5:0] o_ber_cnt
);

  localparam int SH_W   = $clog2(SH_CNT_MAX) + 1;
  localparam int INV_W  = $clog2(SH_INVLD_MAX) + 1;
  localparam int HOLD_W = $clog2(SLIP_HOLDOFF) + 1;

  localparam logic [SH_W-1:0]   SH_LAST   = SH_W'(SH_CNT_MAX);
  localparam logic [INV_W-1:0]  INV_LAST  = INV_W'(SH_INVLD_MAX);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SLIP_HOLDOFF - 1);

  typedef enum logic [1:0] {
    HUNT      = 2'd0,
    LOCKED    = 2'd1,
    SLIP_WAIT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [SH_W-1:0]   sh_cnt_q, sh_cnt_d, sh_cnt_inc;
  logic [INV_W-1:0]  sh_invld_q, sh_invld_d, sh_invld_inc;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              slip_q, slip_d;
  logic              lock_q, lock_d;
  logic              hdr_invld;

  // 2'b00 and 2'b11 are the two illegal sync headers.
  assign hdr_invld    = (i_sync_hdr[1] == i_sync_hdr[0]);
  assign sh_cnt_inc   = sh_cnt_q + 1'b1;
  assign sh_invld_inc = sh_invld_q + INV_W'(hdr_invld);

  always_comb begin
    state_d    = state_q;
    sh_cnt_d   = sh_cnt_q;
    sh_invld_d = sh_invld_q;
    hold_d     = hold_q;
    slip_d     = 1'b0;
    lock_d     = lock_q;
    case (state_q)
      HUNT: begin
        if (i_hdr_valid) begin
          if (hdr_invld) begin
            slip_d     = 1'b1;
            sh_cnt_d   = '0;
            sh_invld_d = '0;
            hold_d     = '0;
            state_d    = SLIP_WAIT;
          end else if (sh_cnt_inc == SH_LAST && sh_invld_q == '0) begin
            lock_d     = 1'b1;
            sh_cnt_d   = '0;
            sh_invld_d = '0;
            state_d    = LOCKED;
          end else begin
            sh_cnt_d = sh_cnt_inc;
          end
        end
      end
      LOCKED: begin
        // Loss of lock is decided on the strobe that hits the limit, even mid-window.
        if (i_hdr_valid) begin
          if (sh_invld_inc == INV_LAST) begin
            lock_d     = 1'b0;
            slip_d     = 1'b1;
            sh_cnt_d   = '0;
            sh_invld_d = '0;
            hold_d     = '0;
            state_d    = SLIP_WAIT;
          end else if (sh_cnt_inc == SH_LAST) begin
            sh_cnt_d   = '0;
            sh_invld_d = '0;
          end else begin
            sh_cnt_d   = sh_cnt_inc;
            sh_invld_d = sh_invld_inc;
          end
        end
      end
      SLIP_WAIT: begin
        if (hold_q == HOLD_LAST) begin
          hold_d  = '0;
          state_d = HUNT;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d    = HUNT;
        sh_cnt_d   = '0;
        sh_invld_d = '0;
        hold_d     = '0;
        lock_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= HUNT;
      sh_cnt_q   <= '0;
      sh_invld_q <= '0;
      hold_q     <= '0;
      slip_q     <= 1'b0;
      lock_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_cnt_q   <= sh_cnt_d;
      sh_invld_q <= sh_invld_d;
      hold_q     <= hold_d;
      slip_q     <= slip_d;
      lock_q     <= lock_d;
    end
  end

  assign o_slip    = slip_q;
  assign o_rx_lock = lock_q;

`ifdef ETH_PCS_RX_HI_BER_EN
  localparam int TMR_W = $clog2(BER_TIMER_CYCLES);

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BER_TIMER_CYCLES - 1);
  localparam logic [5:0]       BER_MAX  = 6'(BER_INVLD_MAX);

  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [5:0]       ber_cnt_q, ber_cnt_d, ber_base;
  logic             hi_ber_q, hi_ber_d;
  logic             ber_wrap, ber_hit;

  always_comb begin
    ber_wrap  = (tmr_q == TMR_LAST);
    ber_hit   = i_hdr_valid && hdr_invld;
    // A hit on the wrap cycle lands in the new window.
    ber_base  = ber_wrap ? 6'd0 : ber_cnt_q;
    ber_cnt_d = (ber_hit && ber_base != 6'd63) ? ber_base + 6'd1 : ber_base;
    tmr_d     = ber_wrap ? '0 : tmr_q + 1'b1;
    hi_ber_d  = hi_ber_q;
    if (ber_wrap && ber_cnt_q < BER_MAX) begin
      hi_ber_d = 1'b0;
    end
    if (ber_hit && ber_cnt_d >= BER_MAX) begin
      hi_ber_d = 1'b1;
    end
    if (state_q != LOCKED || state_d != LOCKED) begin
      tmr_d     = '0;
      ber_cnt_d = '0;
      hi_ber_d  = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      tmr_q     <= '0;
      ber_cnt_q <= '0;
      hi_ber_q  <= 1'b0;
    end else begin
      tmr_q     <= tmr_d;
      ber_cnt_q <= ber_cnt_d;
      hi_ber_q  <= hi_ber_d;
    end
  end

  assign o_hi_ber  = hi_ber_q;
  assign o_ber_cnt = ber_cnt_q;
`else
  // The BER parameters stay referenced so both builds share one parameter list.
  assign o_hi_ber  = (BER_TIMER_CYCLES > 0 && BER_INVLD_MAX > 0) ? 1'b0 : 1'b0;
  assign o_ber_cnt = 6'd0;
`endif

endmodule

// File: tb/tb_eth_pcs_rx_sync_ctrl.sv
// Directed bench for eth_pcs_rx_sync_ctrl: lock, hunt slip, loss of lock, hi_ber, async reset.
module tb_eth_pcs_rx_sync_ctrl;

`ifdef ETH_PCS_RX_HI_BER_EN
  localparam bit BER_ON = 1'b1;
`else
  localparam bit BER_ON = 1'b0;
`endif

  logic       clk;
  logic       i_reset;
  logic       i_hdr_valid;
  logic [1:0] i_sync_hdr;
  logic       o_slip;
  logic       o_rx_lock;
  logic       o_hi_ber;
  logic [5:0] o_ber_cnt;

  int tests;
  int fails;
  int cyc;

  eth_pcs_rx_sync_ctrl #(
    .SH_CNT_MAX      (64),
    .SH_INVLD_MAX    (16),
    .SLIP_HOLDOFF    (4),
    .BER_TIMER_CYCLES(200),
    .BER_INVLD_MAX   (16)
  ) dut (
    .i_clk      (clk),
    .i_reset    (i_reset),
    .i_hdr_valid(i_hdr_valid),
    .i_sync_hdr (i_sync_hdr),
    .o_slip     (o_slip),
    .o_rx_lock  (o_rx_lock),
    .o_hi_ber   (o_hi_ber),
    .o_ber_cnt  (o_ber_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send(input logic v, input logic [1:0] h);
    i_hdr_valid = v;
    i_sync_hdr  = h;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    i_reset     = 1'b1;
    i_hdr_valid = 1'b0;
    i_sync_hdr  = 2'b01;
    repeat (2) @(posedge clk);
    #1;
    i_reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    send(1'b0, 2'b01);
    tests++; if (o_slip !== 1'b0) begin fails++; $display("FAIL reset_slip: got %b want 0", o_slip); end
    tests++; if (o_rx_lock !== 1'b0) begin fails++; $display("FAIL reset_lock: got %b want 0", o_rx_lock); end
    tests++; if (o_hi_ber !== 1'b0) begin fails++; $display("FAIL reset_hi_ber: got %b want 0", o_hi_ber); end
    tests++; if (o_ber_cnt !== 6'd0) begin fails++; $display("FAIL reset_ber_cnt: got %0d want 0", o_ber_cnt); end
  endtask

  task automatic test_lock_acq();
    logic slip_seen;
    slip_seen = 1'b0;
    for (int i = 0; i < 63; i++) begin
      send(1'b1, i[0] ? 2'b10 : 2'b01);
      slip_seen |= o_slip;
    end
    tests++; if (o_rx_lock !== 1'b0) begin fails++; $display("FAIL lock_acq_63: got %b want 0", o_rx_lock); end
    send(1'b1, 2'b10);
    slip_seen |= o_slip;
    tests++; if (o_rx_lock !== 1'b1) begin fails++; $display("FAIL lock_acq_64: got %b want 1", o_rx_lock); end
    tests++; if (slip_seen !== 1'b0) begin fails++; $display("FAIL lock_acq_no_slip: got %b want 0", slip_seen); end
  endtask

  task automatic test_hunt_slip();
    logic slip_seen;
    do_reset();
    for (int i = 0; i < 10; i++) send(1'b1, 2'b01);
    send(1'b1, 2'b11);
    tests++; if (o_slip !== 1'b1) begin fails++; $display("FAIL hunt_slip_pulse: got %b want 1", o_slip); end
    slip_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 2'b00);
      slip_seen |= o_slip;
    end
    tests++; if (slip_seen !== 1'b0) begin fails++; $display("FAIL hunt_holdoff_no_slip: got %b want 0", slip_seen); end
    send(1'b1, 2'b11);
    tests++; if (o_slip !== 1'b1) begin fails++; $display("FAIL hunt_slip_spacing: got %b want 1", o_slip); end
    for (int i = 0; i < 4; i++) send(1'b0, 2'b01);
    tests++; if (o_slip !== 1'b0) begin fails++; $display("FAIL hunt_slip_single: got %b want 0", o_slip); end
    for (int i = 0; i < 63; i++) send(1'b1, 2'b01);
    tests++; if (o_rx_lock !== 1'b0) begin fails++; $display("FAIL hunt_restart_63: got %b want 0", o_rx_lock); end
    send(1'b1, 2'b01);
    tests++; if (o_rx_lock !== 1'b1) begin fails++; $display("FAIL hunt_restart_64: got %b want 1", o_rx_lock); end
  endtask

  task automatic test_loss_of_lock();
    logic slip_seen;
    slip_seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      send(1'b1, 2'b00);
      slip_seen |= o_slip;
    end
    tests++; if (o_ber_cnt !== (BER_ON ? 6'd15 : 6'd0)) begin fails++; $display("FAIL loss_ber_15: got %0d want %0d", o_ber_cnt, BER_ON ? 15 : 0); end
    tests++; if (o_hi_ber !== 1'b0) begin fails++; $display("FAIL loss_hi_ber_15: got %b want 0", o_hi_ber); end
    for (int i = 0; i < 49; i++) begin
      send(1'b1, 2'b01);
      slip_seen |= o_slip;
    end
    tests++; if (o_rx_lock !== 1'b1) begin fails++; $display("FAIL loss_keep_15: got %b want 1", o_rx_lock); end
    tests++; if (slip_seen !== 1'b0) begin fails++; $display("FAIL loss_keep_no_slip: got %b want 0", slip_seen); end
    for (int i = 0; i < 15; i++) send(1'b1, 2'b11);
    tests++; if (o_rx_lock !== 1'b1) begin fails++; $display("FAIL loss_window_cleared: got %b want 1", o_rx_lock); end
    send(1'b1, 2'b00);
    tests++; if (o_rx_lock !== 1'b0) begin fails++; $display("FAIL loss_lock_drop: got %b want 0", o_rx_lock); end
    tests++; if (o_slip !== 1'b1) begin fails++; $display("FAIL loss_slip: got %b want 1", o_slip); end
    tests++; if (o_hi_ber !== 1'b0 || o_ber_cnt !== 6'd0) begin fails++; $display("FAIL loss_ber_clear: got %b/%0d want 0/0", o_hi_ber, o_ber_cnt); end
    send(1'b0, 2'b01);
    tests++; if (o_slip !== 1'b0) begin fails++; $display("FAIL loss_slip_single: got %b want 0", o_slip); end
  endtask

  task automatic test_hi_ber();
    do_reset();
    for (int i = 0; i < 64; i++) send(1'b1, 2'b01);
    tests++; if (o_rx_lock !== 1'b1) begin fails++; $display("FAIL ber_lock: got %b want 1", o_rx_lock); end
    cyc = 0;
    for (int i = 0; i < 8; i++) send(1'b1, 2'b00);
    for (int i = 0; i < 56; i++) send(1'b1, 2'b01);
    for (int i = 0; i < 7; i++) send(1'b1, 2'b11);
    tests++; if (o_ber_cnt !== (BER_ON ? 6'd15 : 6'd0)) begin fails++; $display("FAIL ber_cnt_15: got %0d want %0d", o_ber_cnt, BER_ON ? 15 : 0); end
    tests++; if (o_hi_ber !== 1'b0) begin fails++; $display("FAIL ber_hi_15: got %b want 0", o_hi_ber); end
    send(1'b1, 2'b00);
    tests++; if (o_ber_cnt !== (BER_ON ? 6'd16 : 6'd0)) begin fails++; $display("FAIL ber_cnt_16: got %0d want %0d", o_ber_cnt, BER_ON ? 16 : 0); end
    tests++; if (o_hi_ber !== BER_ON) begin fails++; $display("FAIL ber_hi_16: got %b want %b", o_hi_ber, BER_ON); end
    tests++; if (o_rx_lock !== 1'b1) begin fails++; $display("FAIL ber_lock_kept: got %b want 1", o_rx_lock); end
    while (cyc < 199) send(1'b0, 2'b01);
    tests++; if (o_ber_cnt !== (BER_ON ? 6'd16 : 6'd0)) begin fails++; $display("FAIL ber_cnt_prewrap: got %0d want %0d", o_ber_cnt, BER_ON ? 16 : 0); end
    send(1'b0, 2'b01);
    tests++; if (o_ber_cnt !== 6'd0) begin fails++; $display("FAIL ber_cnt_wrap1: got %0d want 0", o_ber_cnt); end
    tests++; if (o_hi_ber !== BER_ON) begin fails++; $display("FAIL ber_hi_wrap1: got %b want %b", o_hi_ber, BER_ON); end
    for (int i = 0; i < 3; i++) send(1'b1, 2'b11);
    while (cyc < 399) send(1'b0, 2'b01);
    tests++; if (o_ber_cnt !== (BER_ON ? 6'd3 : 6'd0)) begin fails++; $display("FAIL ber_cnt_3: got %0d want %0d", o_ber_cnt, BER_ON ? 3 : 0); end
    tests++; if (o_hi_ber !== BER_ON) begin fails++; $display("FAIL ber_hi_held: got %b want %b", o_hi_ber, BER_ON); end
    send(1'b1, 2'b00);
    tests++; if (o_hi_ber !== 1'b0) begin fails++; $display("FAIL ber_hi_wrap2: got %b want 0", o_hi_ber); end
    tests++; if (o_ber_cnt !== (BER_ON ? 6'd1 : 6'd0)) begin fails++; $display("FAIL ber_cnt_wrap_hit: got %0d want %0d", o_ber_cnt, BER_ON ? 1 : 0); end
    tests++; if (o_rx_lock !== 1'b1) begin fails++; $display("FAIL ber_lock_end: got %b want 1", o_rx_lock); end
  endtask

  task automatic test_async_reset();
    #3;
    i_reset = 1'b1;
    #1;
    tests++; if (o_rx_lock !== 1'b0) begin fails++; $display("FAIL async_lock: got %b want 0", o_rx_lock); end
    tests++; if (o_slip !== 1'b0 || o_hi_ber !== 1'b0 || o_ber_cnt !== 6'd0) begin fails++; $display("FAIL async_outs: got %b/%b/%0d want 0/0/0", o_slip, o_hi_ber, o_ber_cnt); end
    @(posedge clk);
    #1;
    i_reset = 1'b0;
    for (int i = 0; i < 63; i++) send(1'b1, 2'b10);
    tests++; if (o_rx_lock !== 1'b0) begin fails++; $display("FAIL async_relock_63: got %b want 0", o_rx_lock); end
    send(1'b1, 2'b01);
    tests++; if (o_rx_lock !== 1'b1) begin fails++; $display("FAIL async_relock_64: got %b want 1", o_rx_lock); end
  endtask

  initial begin
    tests       = 0;
    fails       = 0;
    cyc         = 0;
    i_reset     = 1'b1;
    i_hdr_valid = 1'b0;
    i_sync_hdr  = 2'b01;
    test_reset();
    test_lock_acq();
    test_loss_of_lock();
    test_hunt_slip();
    test_hi_ber();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/eth_pcs_rx_sync_ctrl.md
# eth_pcs_rx_sync_ctrl

Receive-side 10GBASE-R block-lock and BER controller. Consumes the 2-bit sync headers from the RX gearbox, runs the block-lock state machine, and drives the gearbox `slip` control until header alignment is found. When built in, a high-BER monitor reports excessive invalid-header rates to the PCS status logic.

## Interface
Parameters:
- `SH_CNT_MAX`, 64: headers per lock-test window.
- `SH_INVLD_MAX`, 16: invalid headers in one window that cause loss of lock.
- `SLIP_HOLDOFF`, 4: cycles after a slip during which headers are ignored.
- `BER_TIMER_CYCLES`, 40283: BER window length in clocks (125 us at 322.27 MHz).
- `BER_INVLD_MAX`, 16: invalid headers in one BER window that set hi_ber.

Ports:
- `i_clk`, in, 1: PCS RX clock.
- `i_reset`, in, 1: asynchronous, active-high reset.
- `i_hdr_valid`, in, 1: `i_sync_hdr` is valid this cycle.
- `i_sync_hdr`, in, 2: sync header; 2'b01 or 2'b10 is valid, 2'b00 or 2'b11 is invalid.
- `o_slip`, out, 1: single-cycle request to shift gearbox alignment by one bit.
- `o_rx_lock`, out, 1: block lock achieved.
- `o_hi_ber`, out, 1: high bit-error-rate indication.
- `o_ber_cnt`, out, 6: saturating invalid-header count for the current BER window.

## Operation
- Counters:
  - `sh_cnt` counts valid-strobed headers.
  - `sh_invld_cnt` counts invalid ones.
  - Widths are `$clog2(max)+1`.
- FSM states: HUNT, LOCKED, SLIP_WAIT. Reset state is HUNT.
- HUNT:
  - Each strobed header increments `sh_cnt`.
  - An invalid header causes `o_slip`, clears both counters, and moves to SLIP_WAIT.
  - When `sh_cnt` reaches `SH_CNT_MAX` with zero invalid headers, `o_rx_lock` goes to 1, the counters clear, and the FSM moves to LOCKED.
- LOCKED:
  - Counts headers.
  - If `sh_invld_cnt` reaches `SH_INVLD_MAX` (checked on the strobe that produces it, even mid-window): `o_rx_lock` goes to 0, `o_slip` pulses, the counters clear, and the FSM moves to SLIP_WAIT.
  - Otherwise, at `sh_cnt == SH_CNT_MAX` both counters clear and the FSM stays LOCKED.
- SLIP_WAIT:
  - A holdoff counter runs `SLIP_HOLDOFF` cycles.
  - `i_hdr_valid` is ignored for the whole holdoff.
  - Then the FSM moves to HUNT.
- A header strobed on the same cycle the window completes is counted in that window first, then the counters clear.
- BER monitor (only with the macro; see Configuration):
  - Active only while `o_rx_lock=1`.
  - Timer counts 0 to `BER_TIMER_CYCLES-1` and wraps.
  - Each invalid header increments `ber_cnt` (saturates at 63).
  - `o_hi_ber` sets when `ber_cnt` reaches `BER_INVLD_MAX`.
  - On timer wrap: `ber_cnt` clears, and `o_hi_ber` clears if `ber_cnt < BER_INVLD_MAX`.
  - An invalid header on the wrap cycle is counted into the new window.
  - Leaving LOCKED clears the timer, `ber_cnt` and `o_hi_ber`.

## Timing
- All outputs are registered.
- Reset values: `o_slip=0`, `o_rx_lock=0`, `o_hi_ber=0`, `o_ber_cnt=0`. FSM resets to HUNT with all counters 0.
- `o_slip`:
  - Asserts exactly one cycle, on the cycle after the header strobe that triggers it.
  - Never asserts in SLIP_WAIT.
  - Minimum spacing between slips is `SLIP_HOLDOFF+1` cycles.
- `o_rx_lock` changes on the cycle after the deciding strobe.
- `o_hi_ber` and `o_ber_cnt` update one cycle after the strobe or timer wrap.
- Asserting `i_reset` mid-operation returns all outputs to their reset values immediately (asynchronously). Release is synchronous to `i_clk`.

## Configuration
- `ETH_PCS_RX_HI_BER_EN`:
  - Defined: BER timer, `ber_cnt` and `o_hi_ber` logic are built as specified.
  - Undefined: no BER logic is generated; `o_hi_ber` and `o_ber_cnt` are tied to 0. Lock/slip behaviour is unchanged.

## Test plan
Unless noted, parameters are the defaults with `BER_TIMER_CYCLES=200` for simulation speed.
- **Lock acquisition:** 64 consecutive strobed 2'b01 headers from reset -> `o_rx_lock=1` the cycle after the 64th strobe; no `o_slip` ever.
- **Hunt slip:** in HUNT, one 2'b11 header after 10 good ones -> `o_slip` high for 1 cycle; headers during the following 4 cycles are ignored (no second slip even if invalid); `sh_cnt` restarts from 0.
- **Loss of lock:** locked, then 16 invalid headers within one 64-header window -> `o_rx_lock=0` and `o_slip` pulse the cycle after the 16th invalid header. 15 invalid headers in a window -> lock retained and counters cleared at the 64th header.
- **hi_ber set/clear:** macro defined, locked, 16 invalid headers (15 is below threshold) inside one 200-cycle window -> `o_hi_ber=1` and `o_ber_cnt=16`. Next window with 3 invalid headers -> `o_hi_ber=0` after that window's wrap.
- **Macro off:** same stimulus as hi_ber set/clear -> `o_hi_ber=0` and `o_ber_cnt=0` throughout; lock behaviour identical.
- **Async reset mid-lock:** assert `i_reset` between clock edges while locked -> `o_rx_lock=0` immediately; after release, 64 good headers are needed to relock.
